// File: rtl/disp_scan_ctrl.sv
`default_nettype none
// ----------------------------------------------------------------------------
// disp_scan_ctrl : frame-synchronous scan controller for a multiplexed
//                  7-segment display (optional DISP_LZB_EN: leading-zero blank)
// Rev 1.0
// ----------------------------------------------------------------------------
module disp_scan_ctrl #(
  parameter int DIGITS   = 8,
  parameter int SCAN_DIV = 50000,
  parameter int DIV_W    = 16
) (
  input  logic                clk,
  input  logic                rst,
  input  logic                upd_valid,
  output logic                upd_ready,
  input  logic [4*DIGITS-1:0] upd_data,
  input  logic [3:0]          upd_num,
  input  logic [DIGITS-1:0]   upd_dp,
  output logic [7:0]          seg_d,
  output logic [DIGITS-1:0]   seg_w,
  output logic                frame_done
);
  localparam int                  c_idx_w   = $clog2(DIGITS);
  localparam logic [DIV_W-1:0]    c_tick    = DIV_W'(SCAN_DIV - 1);
  localparam logic [DIV_W-1:0]    c_pre_one = DIV_W'(1);
  localparam logic [c_idx_w-1:0]  c_idx_one = c_idx_w'(1);
  localparam logic [DIGITS-1:0]   c_w_one   = DIGITS'(1);
  localparam logic [3:0]          c_digits  = 4'(DIGITS);

  typedef enum logic [0:0] {
    ST_OFF  = 1'b0,
    ST_SCAN = 1'b1
  } state_e;

  state_e              state_q;
  logic                pend_q;
  logic [4*DIGITS-1:0] sh_data_q;
  logic [4*DIGITS-1:0] act_data_q;
  logic [DIGITS-1:0]   sh_dp_q;
  logic [DIGITS-1:0]   act_dp_q;
  logic [3:0]          sh_num_q;
  logic [3:0]          act_num_q;
  logic [3:0]          sh_num_d;
  logic [DIV_W-1:0]    pre_q;
  logic [c_idx_w-1:0]  idx_q;
  logic [7:0]          seg_d_q;
  logic [DIGITS-1:0]   seg_w_q;
  logic                frame_done_q;

  logic                w_xfer;
  logic                w_tick;
  logic                w_last;
  logic [3:0]          w_nib;
  logic                w_dp;
  logic                w_blank;

  function automatic logic [6:0] hex7(input logic [3:0] n);
    case (n)
      4'h0: hex7 = 7'h3F;
      4'h1: hex7 = 7'h06;
      4'h2: hex7 = 7'h5B;
      4'h3: hex7 = 7'h4F;
      4'h4: hex7 = 7'h66;
      4'h5: hex7 = 7'h6D;
      4'h6: hex7 = 7'h7D;
      4'h7: hex7 = 7'h07;
      4'h8: hex7 = 7'h7F;
      4'h9: hex7 = 7'h6F;
      4'hA: hex7 = 7'h77;
      4'hB: hex7 = 7'h7C;
      4'hC: hex7 = 7'h39;
      4'hD: hex7 = 7'h5E;
      4'hE: hex7 = 7'h79;
      default: hex7 = 7'h71;
    endcase
  endfunction

  assign upd_ready  = ~pend_q;
  assign w_xfer     = upd_valid & ~pend_q;
  assign w_tick     = (state_q == ST_SCAN) && (pre_q == c_tick);
  assign w_last     = ({{(4-c_idx_w){1'b0}}, idx_q} == (act_num_q - 4'd1));
  assign seg_d      = seg_d_q;
  assign seg_w      = seg_w_q;
  assign frame_done = frame_done_q;

  always_comb begin
    if (upd_num == 4'd0) begin
      sh_num_d = 4'd1;
    end else if (upd_num > c_digits) begin
      sh_num_d = c_digits;
    end else begin
      sh_num_d = upd_num;
    end
  end

  // Digit currently addressed by idx, plus its blanking decision.
  always_comb begin
    w_nib   = 4'h0;
    w_dp    = 1'b0;
    w_blank = 1'b0;
    for (int j = 0; j < DIGITS; j++) begin
      if (int'(idx_q) == j) begin
        w_nib = act_data_q[4*j +: 4];
        w_dp  = act_dp_q[j];
      end
    end
`ifdef DISP_LZB_EN
    w_blank = (idx_q != '0);
    for (int j = 0; j < DIGITS; j++) begin
      if ((j >= int'(idx_q)) && (j < int'(act_num_q)) && (act_data_q[4*j +: 4] != 4'h0)) begin
        w_blank = 1'b0;
      end
    end
`endif
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      state_q      <= ST_OFF;
      pend_q       <= 1'b0;
      sh_data_q    <= '0;
      sh_dp_q      <= '0;
      sh_num_q     <= '0;
      act_data_q   <= '0;
      act_dp_q     <= '0;
      act_num_q    <= '0;
      pre_q        <= '0;
      idx_q        <= '0;
      seg_d_q      <= '0;
      seg_w_q      <= '0;
      frame_done_q <= 1'b0;
    end else begin
      frame_done_q <= 1'b0;
      // Transfer and commit are exclusive: one needs pend clear, the other set.
      if (w_xfer) begin
        sh_data_q <= upd_data;
        sh_dp_q   <= upd_dp;
        sh_num_q  <= sh_num_d;
        pend_q    <= 1'b1;
      end
      case (state_q)
        ST_OFF: begin
          pre_q   <= '0;
          seg_w_q <= '0;
          seg_d_q <= '0;
          if (pend_q) begin
            act_data_q <= sh_data_q;
            act_dp_q   <= sh_dp_q;
            act_num_q  <= sh_num_q;
            pend_q     <= 1'b0;
            idx_q      <= '0;
            state_q    <= ST_SCAN;
          end
        end
        ST_SCAN: begin
          seg_w_q <= c_w_one << idx_q;
          seg_d_q <= {w_dp, (w_blank ? 7'h00 : hex7(w_nib))};
          if (w_tick) begin
            pre_q <= '0;
            if (w_last) begin
              idx_q        <= '0;
              frame_done_q <= 1'b1;
              if (pend_q) begin
                act_data_q <= sh_data_q;
                act_dp_q   <= sh_dp_q;
                act_num_q  <= sh_num_q;
                pend_q     <= 1'b0;
              end
            end else begin
              idx_q <= idx_q + c_idx_one;
            end
          end else begin
            pre_q <= pre_q + c_pre_one;
          end
        end
        default: state_q <= ST_OFF;
      endcase
    end
  end

endmodule
`default_nettype wire

// File: tb/tb_disp_scan_ctrl.sv
`default_nettype none
// tb_disp_scan_ctrl : directed + randomized check of disp_scan_ctrl against a
// frame-time behavioural model.
`timescale 1ns/1ps
module tb_disp_scan_ctrl;
  localparam int DIGITS   = 8;
  localparam int SCAN_DIV = 4;
  localparam int DIV_W    = 4;

  logic        clk = 1'b0;
  logic        rst = 1'b1;
  logic        upd_valid = 1'b0;
  logic        upd_ready;
  logic [31:0] upd_data = '0;
  logic [3:0]  upd_num = '0;
  logic [7:0]  upd_dp = '0;
  logic [7:0]  seg_d;
  logic [7:0]  seg_w;
  logic        frame_done;

  int errors = 0;
  int checks = 0;

  always #5 clk = ~clk;

  disp_scan_ctrl #(.DIGITS(DIGITS), .SCAN_DIV(SCAN_DIV), .DIV_W(DIV_W)) dut (
    .clk(clk), .rst(rst), .upd_valid(upd_valid), .upd_ready(upd_ready),
    .upd_data(upd_data), .upd_num(upd_num), .upd_dp(upd_dp),
    .seg_d(seg_d), .seg_w(seg_w), .frame_done(frame_done)
  );

  logic [6:0] hex_tab [16] = '{7'h3F, 7'h06, 7'h5B, 7'h4F, 7'h66, 7'h6D, 7'h7D, 7'h07,
                               7'h7F, 7'h6F, 7'h77, 7'h7C, 7'h39, 7'h5E, 7'h79, 7'h71};

  task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s: got %0h expected %0h at %0t", name, act, exp, $time);
    end
  endtask

  // Model: display state is "time into the current frame"; the slot is t/SCAN_DIV.
  bit          m_on, m_pend, chk_en;
  logic [31:0] m_sh_data, m_act_data;
  logic [7:0]  m_sh_dp, m_act_dp;
  int          m_sh_num, m_act_num, m_t;
  logic [7:0]  e_w, e_d;
  logic        e_fd;

  always @(posedge clk) begin
    bit xfer;
    bit blank;
    int i;
    if (rst) begin
      m_on = 0; m_pend = 0; m_t = 0;
      m_sh_data = 0; m_sh_dp = 0; m_sh_num = 0;
      m_act_data = 0; m_act_dp = 0; m_act_num = 0;
      e_w = 0; e_d = 0; e_fd = 0;
      chk_en = 1;
    end else begin
      xfer = upd_valid && !m_pend;
      if (m_on) begin
        i = m_t / SCAN_DIV;
        blank = 0;
`ifdef DISP_LZB_EN
        blank = (i > 0);
        for (int j = i; j < m_act_num; j++)
          if (m_act_data[4*j +: 4] != 4'h0) blank = 0;
`endif
        e_w  = 8'b1 << i;
        e_d  = {m_act_dp[i], (blank ? 7'h00 : hex_tab[m_act_data[4*i +: 4]])};
        e_fd = (m_t == m_act_num * SCAN_DIV - 1);
        if (e_fd) begin
          m_t = 0;
          if (m_pend) begin
            m_act_data = m_sh_data; m_act_dp = m_sh_dp; m_act_num = m_sh_num; m_pend = 0;
          end
        end else begin
          m_t++;
        end
      end else begin
        e_w = 0; e_d = 0; e_fd = 0;
        if (m_pend) begin
          m_act_data = m_sh_data; m_act_dp = m_sh_dp; m_act_num = m_sh_num; m_pend = 0;
          m_on = 1; m_t = 0;
        end
      end
      if (xfer) begin
        m_sh_data = upd_data;
        m_sh_dp   = upd_dp;
        m_sh_num  = (upd_num == 0) ? 1 : ((int'(upd_num) > DIGITS) ? DIGITS : int'(upd_num));
        m_pend    = 1;
      end
    end
  end

  always @(negedge clk) begin
    if (chk_en) begin
      check("seg_w", 32'(seg_w), 32'(e_w));
      check("seg_d", 32'(seg_d), 32'(e_d));
      check("frame_done", 32'(frame_done), 32'(e_fd));
      check("upd_ready", 32'(upd_ready), 32'(!m_pend));
    end
  end

  task automatic do_reset();
    rst = 1'b1;
    upd_valid = 1'b0;
    repeat (2) @(negedge clk);
    rst = 1'b0;
  endtask

  // Returns on the negedge just after the transfer edge.
  task automatic send(input logic [31:0] d, input logic [3:0] n, input logic [7:0] dp);
    int k;
    upd_data = d; upd_num = n; upd_dp = dp; upd_valid = 1'b1;
    k = 0;
    while (!upd_ready && k < 200) begin
      @(negedge clk);
      k++;
    end
    check("send_ready", 32'(upd_ready), 32'd1);
    @(negedge clk);
    upd_valid = 1'b0;
  endtask

  task automatic wait_fd();
    int k;
    k = 0;
    while (!frame_done && k < 200) begin
      @(negedge clk);
      k++;
    end
    check("wait_frame_done", 32'(frame_done), 32'd1);
  endtask

  task automatic wait_w(input logic [7:0] target);
    int k;
    k = 0;
    while (seg_w !== target && k < 200) begin
      @(negedge clk);
      k++;
    end
    check("wait_seg_w", 32'(seg_w), 32'(target));
  endtask

  initial begin
    int fd_cnt;
    do_reset();

    fd_cnt = 0;
    repeat (100) begin
      @(negedge clk);
      fd_cnt += int'(frame_done);
    end
    check("idle_fd_count", fd_cnt, 0);
    check("idle_seg_w", 32'(seg_w), 32'h0);
    check("idle_seg_d", 32'(seg_d), 32'h0);
    check("idle_ready", 32'(upd_ready), 32'd1);

    send(32'h0000_0123, 4'd3, 8'h00);
    repeat (2) @(negedge clk);
    check("first_w0", 32'(seg_w), 32'h01);
    check("first_d0", 32'(seg_d), 32'h4F);
    repeat (4) @(negedge clk);
    check("first_w1", 32'(seg_w), 32'h02);
    check("first_d1", 32'(seg_d), 32'h5B);
    repeat (4) @(negedge clk);
    check("first_w2", 32'(seg_w), 32'h04);
    check("first_d2", 32'(seg_d), 32'h06);
    fd_cnt = 0;
    repeat (48) begin
      @(negedge clk);
      fd_cnt += int'(frame_done);
    end
    check("frame_period", fd_cnt, 4);

    wait_w(8'h02);
    send(32'h0000_0456, 4'd3, 8'h00);
    check("tear_pend", 32'(upd_ready), 32'd0);
    wait_fd();
    check("tear_old_last", 32'(seg_d), 32'h06);
    check("tear_ready_back", 32'(upd_ready), 32'd1);
    @(negedge clk);
    check("tear_new_first", 32'(seg_d), 32'h7D);

    wait_fd();
    repeat (11) @(negedge clk);
    send(32'h0000_0789, 4'd3, 8'h00);
    check("collide_fd", 32'(frame_done), 32'd1);
    check("collide_pend", 32'(upd_ready), 32'd0);
    @(negedge clk);
    check("collide_old", 32'(seg_d), 32'h7D);
    wait_fd();
    @(negedge clk);
    check("collide_new", 32'(seg_d), 32'h6F);

    do_reset();
    send(32'h0000_0008, 4'd0, 8'h01);
    repeat (2) @(negedge clk);
    check("clamp1_w", 32'(seg_w), 32'h01);
    check("clamp1_d", 32'(seg_d), 32'hFF);
    fd_cnt = 0;
    repeat (40) begin
      @(negedge clk);
      fd_cnt += int'(frame_done);
    end
    check("clamp1_fd_count", fd_cnt, 10);
    check("clamp1_w_stuck", 32'(seg_w), 32'h01);

    do_reset();
    send(32'h7654_3210, 4'd12, 8'h00);
    wait_w(8'h80);
    check("clamp8_d7", 32'(seg_d), 32'h07);
    send(32'hAAAA_AAAA, 4'd8, 8'hFF);
    rst = 1'b1;
    @(negedge clk);
    check("rst_w", 32'(seg_w), 32'h0);
    check("rst_d", 32'(seg_d), 32'h0);
    check("rst_ready", 32'(upd_ready), 32'd1);
    rst = 1'b0;
    repeat (20) @(negedge clk);
    check("rst_shadow_dropped", 32'(seg_w), 32'h0);

    send(32'h0000_0010, 4'd4, 8'h00);
    wait_w(8'h08);
`ifdef DISP_LZB_EN
    check("lzb_d3", 32'(seg_d), 32'h00);
    wait_w(8'h04);
    check("lzb_d2", 32'(seg_d), 32'h00);
`else
    check("lzb_d3", 32'(seg_d), 32'h3F);
    wait_w(8'h04);
    check("lzb_d2", 32'(seg_d), 32'h3F);
`endif
    wait_w(8'h01);
    check("lzb_d0", 32'(seg_d), 32'h3F);
    wait_w(8'h02);
    check("lzb_d1", 32'(seg_d), 32'h06);

    do_reset();
    repeat (3000) begin
      @(negedge clk);
      rst       = ($urandom_range(0, 499) == 0);
      upd_valid = ($urandom_range(0, 9) == 0);
      upd_data  = $urandom;
      upd_num   = 4'($urandom_range(0, 15));
      upd_dp    = 8'($urandom);
    end
    @(negedge clk);
    rst = 1'b0;
    upd_valid = 1'b0;
    repeat (4) @(negedge clk);

    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end

endmodule
`default_nettype wire

// File: doc/disp_scan_ctrl.md
Name: disp_scan_ctrl

Overview:
- Scan controller and scheduler for the calculator's multiplexed 7-segment display.
- Accepts a new display word from the calculator core through a valid/ready handshake and holds it in a shadow register.
- Commits the shadow word only at a frame boundary, so a frame never shows a mix of old and new digits.
- Generates the digit-slot timing, one-hot digit select (seg_w) and decoded segment data (seg_d).

Parameters:
- DIGITS, 8: number of physical digits; legal range 2..8.
- SCAN_DIV, 50000: clk cycles per digit slot; must be >= 2.
- DIV_W, 16: prescaler counter width; must satisfy 2^DIV_W >= SCAN_DIV.

Ports:
- clk, in, 1: system clock.
- rst, in, 1: synchronous active-high reset.
- upd_valid, in, 1: new display word offered.
- upd_ready, out, 1: controller can accept a word.
- upd_data, in, 4*DIGITS: hex nibbles. Digit i is upd_data[4i+3:4i]; digit 0 is the rightmost, least significant digit.
- upd_num, in, 4: number of active digits to scan.
- upd_dp, in, DIGITS: decimal point per digit, 1 = lit.
- seg_d, out, 8: segments, active-high. bit0 = a … bit6 = g, bit7 = dp.
- seg_w, out, DIGITS: digit select, one-hot, active-high.
- frame_done, out, 1: one-cycle pulse when the last active digit slot ends.

Behaviour:
- Reset: only clk and rst are sampled. Reset values:
  - seg_d = 0, seg_w = 0, frame_done = 0, upd_ready = 1.
  - pend = 0, prescaler = 0, idx = 0; shadow and active registers cleared.
  - state = OFF.
  - A reset asserted mid-frame or mid-handshake discards all pending and active data.
- upd_ready = !pend (combinational). A transfer occurs when upd_valid && upd_ready && !rst.
  - On transfer: shadow <= {upd_data, upd_dp, clamp(upd_num)} and pend <= 1.
  - clamp: 0 becomes 1; values above DIGITS become DIGITS.
- States:
  - OFF: seg_w = 0, seg_d = 0, prescaler held at 0. If pend is set: commit shadow to active, clear pend, idx <= 0, go to SCAN.
  - SCAN: the prescaler counts 0..SCAN_DIV-1 and wraps. tick is asserted when prescaler == SCAN_DIV-1.
    - On tick with idx < num_act-1: idx <= idx+1.
    - On tick with idx == num_act-1: idx <= 0 and frame_done pulses in the following cycle (registered).
    - If pend is set at that same tick: commit shadow to active and clear pend (frame boundary commit).
- Simultaneous transfer and frame boundary: the commit uses the pre-update pend value. A word accepted in the boundary cycle therefore commits at the next boundary, or next cycle if in OFF.
- Outputs are registered, one cycle after idx/active change:
  - seg_w = 1 << idx.
  - seg_d = {active_dp[idx], hex7(active_nibble[idx])}.
- hex7 encoding:
  - 0 = 0x3F, 1 = 0x06, 2 = 0x5B, 3 = 0x4F, 4 = 0x66, 5 = 0x6D, 6 = 0x7D, 7 = 0x07
  - 8 = 0x7F, 9 = 0x6F, A = 0x77, b = 0x7C, C = 0x39, d = 0x5E, E = 0x79, F = 0x71
- Inactive digits (index >= num_act) are never selected.
- num_act = 1: idx stays 0; frame_done pulses once every SCAN_DIV cycles.
- Once in SCAN, the controller never returns to OFF except via rst.

Optional Feature:
- Macro: DISP_LZB_EN (leading-zero blanking).
- Defined: for an active digit i > 0, if nibbles i..num_act-1 are all zero, seg_d[6:0] = 0. The dp bit is still driven and seg_w is still asserted. Digit 0 is never blanked.
- Not defined: every active digit is displayed, including leading zeros.

Test Plan:
- Idle after reset (SCAN_DIV=4, DIGITS=8): rst held 2 cycles then released, upd_valid=0 for 100 cycles -> seg_w = 0, seg_d = 0, frame_done never pulses, upd_ready = 1.
- First update: upd_data = 0x00000123, upd_num = 3, upd_dp = 0 -> seg_w = 0x01 and seg_d = 0x4F, 2 cycles after transfer. The display then steps through seg_w = 0x02/0x5B and 0x04/0x06 every 4 cycles. frame_done pulses every 12 cycles.
- Tear-free update: mid-frame, send 0x00000456 -> upd_ready = 0 until the boundary. Old digits complete the frame; the new frame starts with seg_d = 0x7D. upd_ready returns to 1 after the commit.
- Boundary collision: transfer lands exactly in the tick cycle of the last slot -> the current frame repeats the old data once; the new data appears one frame later.
- Clamp and dp: upd_num = 0 with upd_dp = 0x01, nibble 0 = 8 -> seg_w stuck at 0x01, seg_d = 0xFF. upd_num = 12 -> 8 digits scanned.
- Reset mid-frame while pend = 1 -> outputs 0 the cycle after rst; state OFF; the shadow word is never displayed.
- With DISP_LZB_EN defined: data 0x00000010, upd_num = 4 -> digits 3 and 2 show seg_d = 0x00, digit 1 shows 0x06, digit 0 shows 0x3F.
